tdc_sweep: RTL and testbench
============================

TDC_SWEEP -- requirements
Module: tdc_sweep

Interface
REQ-001 Parameter CHANNELS, default 2, number of echo inputs sampled in parallel (1..16).
REQ-002 Parameter PERIOD, default 64, test-impulse period in clk100 cycles (4..255).
REQ-003 Parameter STEPS, default 128, phase positions per sweep leg (2..255).
REQ-004 Parameter REPS, default 16, periods accumulated per phase position (1..255).
REQ-005 Parameter CNT_W, default 8, hit-counter width (1..16).
REQ-006 Parameter STEP_TIME, default 8, period-counter value at which phase_step is raised.
REQ-007 clk100  in  1  sole clock; same clock drives PLL scanclk.
REQ-008 wlocked  in  1  reset, asynchronous, active-low (PLL locked).
REQ-009 echo_in  in  CHANNELS  raw echo pins, sampled without synchroniser (intentional TDC metastability).
REQ-010 cap_time  in  8  period-counter value at which echo_in is sampled.
REQ-011 start  in  1  one-cycle pulse, begins sweep from IDLE.
REQ-012 continuous  in  1  0 = one up+down sweep then IDLE; 1 = repeat until stop.
REQ-013 stop  in  1  one-cycle pulse, finish current step then IDLE.
REQ-014 phase_step / phase_updown  out  1 / 1  PLL phase-step request and direction (1 = up).
REQ-015 phase_done  in  1  active-high phase-step acknowledge (already inverted from PLL).
REQ-016 period_cnt  out  8  free-running 0..PERIOD-1 counter for test-impulse alignment.
REQ-017 rec_valid / rec_ready  out / in  1 / 1  result record handshake.
REQ-018 rec_step, rec_dir, rec_chan, rec_count  out  8, 1, clog2(CHANNELS), CNT_W  record fields.
REQ-019 busy, err_timeout, err_captime  out  1 each  status.

Function
REQ-020 period_cnt SHALL count 0..PERIOD-1 and wrap every clock while wlocked high, independent of FSM state.
REQ-021 FSM states SHALL be IDLE, SETTLE, ACCUM, EMIT, STEP; busy = state != IDLE.
REQ-022 IDLE->SETTLE on start; step index = 0, dir = up; start ignored when busy.
REQ-023 SETTLE SHALL wait 2 full periods (period_cnt wrap to 0) then enter ACCUM, clearing all hit counters.
REQ-024 ACCUM: when period_cnt == cap_time, each channel registers echo_in bit; next cycle counter increments if bit = 1, saturating at 2^CNT_W-1.
REQ-025 ACCUM SHALL leave for EMIT after REPS capture events.
REQ-026 EMIT SHALL present one record per channel, ascending rec_chan; fields stable while rec_valid=1 and rec_ready=0; advance only on valid&ready; rec_valid registered.
REQ-027 After last channel accepted, EMIT->STEP; FSM never changes phase while records are pending (full backpressure).
REQ-028 STEP: phase_step rises on period_cnt == STEP_TIME, falls the cycle after phase_done=1; phase_updown = dir, stable throughout.
REQ-029 phase_done not seen within 255 cycles of phase_step rise: drop phase_step, set sticky err_timeout, proceed as if done.
REQ-030 On step completion: up leg increments index; index reaching STEPS-1 flips dir to down; down leg decrements; index reaching 0 completes sweep.
REQ-031 Sweep complete: continuous=1 -> SETTLE with dir up; else IDLE.
REQ-032 stop pulse SHALL be latched; honoured at next step completion (IDLE), not mid-EMIT.
REQ-033 cap_time >= PERIOD: no captures, err_captime set continuously; ACCUM SHALL still exit after REPS periods with zero counts.
REQ-034 Simultaneous start and stop in IDLE: stop wins, stay IDLE.

Reset
REQ-035 wlocked low SHALL asynchronously clear: state IDLE, period_cnt 0, index 0, dir up, counters 0, phase_step 0, phase_updown 0, rec_valid 0, all rec fields 0, busy 0, err flags 0, stop latch 0.
REQ-036 Reset mid-STEP SHALL drop phase_step immediately; PLL phase position is not restored.

Structure
REQ-037 Package tdc_pkg SHALL hold state encoding, SETTLE_PERIODS = 2, TIMEOUT = 255.
REQ-038 Sub-module tdc_chan_acc SHALL implement one channel's sample register and saturating counter, generated CHANNELS times.

Verification
REQ-039 CHANNELS=2, REPS=4, echo_in=2'b01 held, rec_ready=1 -> per step records ch0 count 4, ch1 count 0.
REQ-040 STEPS=4, continuous=0, phase_done one cycle after request -> rec_step order 0,1,2,3,2,1,0 with rec_dir 1,1,1,0,0,0,0 (final step-to-0 on down leg), then busy=0.
REQ-041 rec_ready=0 for 500 cycles in EMIT -> rec fields stable, phase_step stays 0.
REQ-042 phase_done tied 0 -> phase_step drops after 255 cycles, err_timeout=1, sweep continues.
REQ-043 CNT_W=2, REPS=10, echo high -> rec_count=3 (saturated).
REQ-044 wlocked low during STEP -> all outputs zero same cycle; start afterwards begins at step 0.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared constants for the TDC phase-sweep controller: FSM encoding,
// settle/timeout limits and a saturating increment helper.
package tdc_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_ACCUM  = 3'd2;
    localparam logic [2:0] ST_EMIT   = 3'd3;
    localparam logic [2:0] ST_STEP   = 3'd4;

    localparam int SETTLE_PERIODS = 2;
    localparam int TIMEOUT        = 255;

    // Counters are at most 16 bits wide, so the helper works on 16-bit values.
    function automatic logic [15:0] sat_inc(input logic [15:0] value, input logic [15:0] max);
        return (value >= max) ? max : value + 16'd1;
    endfunction

endpackage

// File: rtl/tdc_chan_acc.sv
// One TDC channel: captures its echo pin at the capture instant and counts
// hits one cycle later, saturating at the all-ones value.
module tdc_chan_acc
    import tdc_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             cap_en,
    input  logic             echo,
    output logic [CNT_W-1:0] count
);

    localparam logic [15:0] CNT_MAX = 16'((32'd1 << CNT_W) - 32'd1);

    logic sample;
    logic hit_pend;

    // The echo pin is registered directly; metastability here is the measurement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample   <= 1'b0;
            hit_pend <= 1'b0;
            count    <= '0;
        end else begin
            hit_pend <= cap_en;
            if (cap_en) begin
                sample <= echo;
            end
            if (clear) begin
                count <= '0;
            end else if (hit_pend && sample) begin
                count <= CNT_W'(sat_inc(16'(count), CNT_MAX));
            end
        end
    end

endmodule

// File: rtl/tdc_sweep.sv
// PLL phase sweep controller: steps the PLL phase up then down, accumulating
// echo hits per channel at each position and emitting one record per channel.
module tdc_sweep
    import tdc_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int PERIOD    = 64,
    parameter int STEPS     = 128,
    parameter int REPS      = 16,
    parameter int CNT_W     = 8,
    parameter int STEP_TIME = 8,
    localparam int CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk100,
    input  logic                wlocked,
    input  logic [CHANNELS-1:0] echo_in,
    input  logic [7:0]          cap_time,
    input  logic                start,
    input  logic                continuous,
    input  logic                stop,
    output logic                phase_step,
    output logic                phase_updown,
    input  logic                phase_done,
    output logic [7:0]          period_cnt,
    output logic                rec_valid,
    input  logic                rec_ready,
    output logic [7:0]          rec_step,
    output logic                rec_dir,
    output logic [CHAN_W-1:0]   rec_chan,
    output logic [CNT_W-1:0]    rec_count,
    output logic                busy,
    output logic                err_timeout,
    output logic                err_captime
);

    localparam logic [7:0]        PERIOD_LAST = 8'(PERIOD - 1);
    localparam logic [7:0]        STEP_T      = 8'(STEP_TIME);
    localparam logic [7:0]        REPS_L      = 8'(REPS);
    localparam logic [7:0]        IDX_LAST    = 8'(STEPS - 1);
    localparam logic [7:0]        TIMER_LAST  = 8'(TIMEOUT - 1);
    localparam logic [1:0]        SETTLE_LAST = 2'(SETTLE_PERIODS - 1);
    localparam logic [CHAN_W-1:0] CHAN_LAST   = CHAN_W'(CHANNELS - 1);

    logic [2:0]        state;
    logic [1:0]        settle_cnt;
    logic [7:0]        rep_cnt;
    logic [7:0]        idx;
    logic              dir;
    logic              stop_lat;
    logic              req_sent;
    logic [7:0]        timer;
    logic              cap_d;

    logic              wrap;
    logic              cap_ok;
    logic              cap_en;
    logic              clear_cnt;
    logic [CHAN_W-1:0] chan_nxt;
    logic [7:0]        idx_next;
    logic              dir_next;
    logic              sweep_end;
    logic [CNT_W-1:0]  counts [CHANNELS];

    assign busy      = (state != ST_IDLE);
    assign wrap      = (period_cnt == PERIOD_LAST);
    assign cap_ok    = (cap_time <= PERIOD_LAST);
    assign cap_en    = (state == ST_ACCUM) && cap_ok && (period_cnt == cap_time) && (rep_cnt != REPS_L);
    assign clear_cnt = (state == ST_SETTLE) && wrap && (settle_cnt == SETTLE_LAST);
    assign chan_nxt  = rec_chan + 1'b1;

    always_ff @(posedge clk100 or negedge wlocked) begin
        if (!wlocked) begin
            period_cnt <= '0;
        end else if (wrap) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 8'd1;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        tdc_chan_acc #(
            .CNT_W (CNT_W)
        ) u_acc (
            .clk    (clk100),
            .rst_n  (wlocked),
            .clear  (clear_cnt),
            .cap_en (cap_en),
            .echo   (echo_in[g]),
            .count  (counts[g])
        );
    end

    // Position after the current step; the down leg ends once it is back at 0.
    always_comb begin
        idx_next  = idx;
        dir_next  = dir;
        sweep_end = !dir && (idx == 8'd0);
        if (dir) begin
            idx_next = idx + 8'd1;
            if (idx_next == IDX_LAST) begin
                dir_next = 1'b0;
            end
        end else if (idx != 8'd0) begin
            idx_next = idx - 8'd1;
        end
    end

    always_ff @(posedge clk100 or negedge wlocked) begin
        if (!wlocked) begin
            state        <= ST_IDLE;
            settle_cnt   <= '0;
            rep_cnt      <= '0;
            idx          <= '0;
            dir          <= 1'b1;
            stop_lat     <= 1'b0;
            req_sent     <= 1'b0;
            timer        <= '0;
            cap_d        <= 1'b0;
            phase_step   <= 1'b0;
            phase_updown <= 1'b0;
            rec_valid    <= 1'b0;
            rec_step     <= '0;
            rec_dir      <= 1'b0;
            rec_chan     <= '0;
            rec_count    <= '0;
            err_timeout  <= 1'b0;
            err_captime  <= 1'b0;
        end else begin
            cap_d       <= cap_en;
            err_captime <= !cap_ok;
            if (stop && busy) begin
                stop_lat <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                        idx        <= '0;
                        dir        <= 1'b1;
                        stop_lat   <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (wrap) begin
                        if (settle_cnt == SETTLE_LAST) begin
                            state   <= ST_ACCUM;
                            rep_cnt <= '0;
                        end else begin
                            settle_cnt <= settle_cnt + 2'd1;
                        end
                    end
                end
                ST_ACCUM: begin
                    // Without a valid capture instant, whole periods stand in for captures.
                    if (cap_en || (!cap_ok && wrap && rep_cnt != REPS_L)) begin
                        rep_cnt <= rep_cnt + 8'd1;
                    end
                    // Wait one more cycle after the last capture so its hit is counted.
                    if (rep_cnt == REPS_L && !cap_d) begin
                        state     <= ST_EMIT;
                        rec_valid <= 1'b1;
                        rec_chan  <= '0;
                        rec_count <= counts[0];
                        rec_step  <= idx;
                        rec_dir   <= dir;
                    end
                end
                ST_EMIT: begin
                    if (rec_ready) begin
                        if (rec_chan == CHAN_LAST) begin
                            rec_valid    <= 1'b0;
                            state        <= ST_STEP;
                            req_sent     <= 1'b0;
                            phase_updown <= dir;
                        end else begin
                            rec_chan  <= chan_nxt;
                            rec_count <= counts[chan_nxt];
                        end
                    end
                end
                ST_STEP: begin
                    if (!phase_step && !req_sent && period_cnt == STEP_T) begin
                        phase_step <= 1'b1;
                        req_sent   <= 1'b1;
                        timer      <= '0;
                    end else if (phase_step) begin
                        if (phase_done || timer == TIMER_LAST) begin
                            phase_step <= 1'b0;
                            if (!phase_done) begin
                                err_timeout <= 1'b1;
                            end
                            idx        <= idx_next;
                            dir        <= dir_next;
                            settle_cnt <= '0;
                            if (stop_lat || (sweep_end && !continuous)) begin
                                state    <= ST_IDLE;
                                stop_lat <= 1'b0;
                            end else if (sweep_end) begin
                                state <= ST_SETTLE;
                                idx   <= '0;
                                dir   <= 1'b1;
                            end else begin
                                state <= ST_SETTLE;
                            end
                        end else begin
                            timer <= timer + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_sweep.sv
// Scoreboard bench for tdc_sweep: directed sweeps push expected records,
// a monitor pops and compares each accepted record.
module tb_tdc_sweep;

    typedef struct packed {
        logic [7:0] step;
        logic       dir;
        logic [0:0] chan;
        logic [7:0] count;
    } rec_t;

    logic       clk100 = 1'b0;
    logic       wlocked;
    logic [1:0] echo_in;
    logic [7:0] cap_time;
    logic       start, continuous, stop, phase_done, rec_ready;
    logic       phase_step, phase_updown, rec_valid, rec_dir, busy, err_timeout, err_captime;
    logic [7:0] period_cnt, rec_step, rec_count;
    logic [0:0] rec_chan;

    logic       s_start, s_stop, s_phase_step, s_phase_updown, s_rec_valid, s_rec_dir;
    logic       s_busy, s_err_timeout, s_err_captime;
    logic [7:0] s_period_cnt, s_rec_step;
    logic [0:0] s_rec_chan;
    logic [1:0] s_rec_count;

    int   n_vec = 0;
    int   n_bad = 0;
    rec_t sb[$];
    logic last_dir = 1'b1;
    logic auto_done = 1'b0;

    always #5 clk100 = ~clk100;

    tdc_sweep #(
        .CHANNELS(2), .PERIOD(16), .STEPS(4), .REPS(4), .CNT_W(8), .STEP_TIME(8)
    ) dut (
        .clk100(clk100), .wlocked(wlocked), .echo_in(echo_in), .cap_time(cap_time),
        .start(start), .continuous(continuous), .stop(stop),
        .phase_step(phase_step), .phase_updown(phase_updown), .phase_done(phase_done),
        .period_cnt(period_cnt), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_step(rec_step), .rec_dir(rec_dir), .rec_chan(rec_chan), .rec_count(rec_count),
        .busy(busy), .err_timeout(err_timeout), .err_captime(err_captime)
    );

    tdc_sweep #(
        .CHANNELS(2), .PERIOD(16), .STEPS(2), .REPS(10), .CNT_W(2), .STEP_TIME(8)
    ) dut_sat (
        .clk100(clk100), .wlocked(wlocked), .echo_in(2'b11), .cap_time(8'd5),
        .start(s_start), .continuous(1'b0), .stop(s_stop),
        .phase_step(s_phase_step), .phase_updown(s_phase_updown), .phase_done(s_phase_step),
        .period_cnt(s_period_cnt), .rec_valid(s_rec_valid), .rec_ready(1'b1),
        .rec_step(s_rec_step), .rec_dir(s_rec_dir), .rec_chan(s_rec_chan), .rec_count(s_rec_count),
        .busy(s_busy), .err_timeout(s_err_timeout), .err_captime(s_err_captime)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic push_step(input int step, input logic dir, input int c0, input int c1);
        sb.push_back('{step: 8'(step), dir: dir, chan: 1'b0, count: 8'(c0)});
        sb.push_back('{step: 8'(step), dir: dir, chan: 1'b1, count: 8'(c1)});
    endtask

    task automatic pulse_start(input logic cont);
        start = 1'b1;
        continuous = cont;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check(name, busy, 0);
    endtask

    task automatic wait_phase_step(input int budget, input string name);
        int n = 0;
        while (!phase_step && n < budget) begin
            tick();
            n++;
        end
        check(name, phase_step, 1);
    endtask

    // Monitor: every record accepted by a valid/ready handshake is compared.
    initial forever begin
        rec_t e;
        @(negedge clk100);
        if (wlocked && rec_valid && rec_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_record: got step %0d dir %0d chan %0d count %0d, expected none",
                         rec_step, rec_dir, rec_chan, rec_count);
            end else begin
                e = sb.pop_front();
                check("record", {rec_step, rec_dir, rec_chan, rec_count}, e);
                last_dir = rec_dir;
            end
        end
    end

    // PLL model: acknowledges a phase step one cycle after the request.
    initial forever begin
        @(posedge clk100);
        #1;
        if (auto_done && phase_step && !phase_done) begin
            check("phase_updown", phase_updown, last_dir);
        end
        phase_done = auto_done && phase_step && !phase_done;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   prev;
        int   hi;
        logic changed;
        logic [17:0] snap;

        wlocked = 1'b1; echo_in = 2'b01; cap_time = 8'd5; start = 1'b0; continuous = 1'b0;
        stop = 1'b0; phase_done = 1'b0; rec_ready = 1'b1; s_start = 1'b0; s_stop = 1'b0;
        #2 wlocked = 1'b0;
        repeat (3) tick();
        check("reset_outputs",
              {phase_step, phase_updown, period_cnt, rec_valid, rec_step, rec_dir, rec_chan,
               rec_count, busy, err_timeout, err_captime}, 0);
        wlocked = 1'b1;

        for (int i = 0; i < 20; i++) begin
            prev = int'(period_cnt);
            tick();
            check("period_cnt_seq", period_cnt, (prev + 1) % 16);
        end

        // Full up/down sweep, ch0 always hit, ch1 never.
        auto_done = 1'b1;
        push_step(0, 1, 4, 0); push_step(1, 1, 4, 0); push_step(2, 1, 4, 0);
        push_step(3, 0, 4, 0); push_step(2, 0, 4, 0); push_step(1, 0, 4, 0);
        push_step(0, 0, 4, 0);
        pulse_start(1'b0);
        check("busy_after_start", busy, 1);
        wait_idle(5000, "sweep_end_idle");
        check("sweep_drained", sb.size(), 0);
        check("sweep_no_timeout", err_timeout, 0);

        // Start and stop together: stop wins.
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        tick();
        check("start_stop_idle", busy, 0);

        // Stop in continuous mode ends after the current step.
        push_step(0, 1, 4, 0);
        pulse_start(1'b1);
        repeat (3) tick();
        pulse_stop();
        wait_idle(2000, "stop_idle");
        check("stop_drained", sb.size(), 0);

        // Backpressure holds the record and blocks stepping.
        push_step(0, 1, 4, 0); push_step(1, 1, 4, 0); push_step(2, 1, 4, 0);
        push_step(3, 0, 4, 0); push_step(2, 0, 4, 0); push_step(1, 0, 4, 0);
        push_step(0, 0, 4, 0);
        rec_ready = 1'b0;
        pulse_start(1'b0);
        begin
            int n = 0;
            while (!rec_valid && n < 1000) begin
                tick();
                n++;
            end
        end
        check("bp_valid", rec_valid, 1);
        snap = {rec_step, rec_dir, rec_chan, rec_count};
        changed = 1'b0;
        repeat (500) begin
            tick();
            if ({rec_step, rec_dir, rec_chan, rec_count} !== snap || rec_valid !== 1'b1 || phase_step !== 1'b0)
                changed = 1'b1;
        end
        check("bp_hold", changed, 0);
        rec_ready = 1'b1;
        wait_idle(5000, "bp_idle");
        check("bp_drained", sb.size(), 0);

        // PLL never acknowledges: each step times out, sweep carries on.
        auto_done = 1'b0;
        echo_in = 2'b10;
        push_step(0, 1, 0, 4);
        push_step(1, 1, 0, 4);
        pulse_start(1'b0);
        wait_phase_step(1000, "to_rise");
        hi = 1;
        while (hi < 400) begin
            tick();
            if (phase_step) hi++;
            else break;
        end
        check("to_width", hi, 255);
        check("to_err", err_timeout, 1);
        check("to_continues", busy, 1);
        pulse_stop();
        wait_idle(3000, "to_idle");
        check("to_drained", sb.size(), 0);
        check("to_sticky", err_timeout, 1);

        // Reset in the middle of a phase step.
        echo_in = 2'b01;
        push_step(0, 1, 4, 0);
        pulse_start(1'b0);
        wait_phase_step(1000, "rst_rise");
        #2 wlocked = 1'b0;
        #1;
        check("rst_mid_step",
              {phase_step, phase_updown, period_cnt, rec_valid, rec_step, rec_dir, rec_chan,
               rec_count, busy, err_timeout, err_captime}, 0);
        tick();
        wlocked = 1'b1;
        auto_done = 1'b1;
        push_step(0, 1, 4, 0);
        pulse_start(1'b0);
        repeat (2) tick();
        pulse_stop();
        wait_idle(2000, "rst_restart_idle");
        check("rst_drained", sb.size(), 0);

        // Capture instant outside the period: no hits, flag raised.
        cap_time = 8'd20;
        echo_in = 2'b11;
        push_step(0, 1, 0, 0);
        pulse_start(1'b0);
        repeat (2) tick();
        check("captime_err", err_captime, 1);
        pulse_stop();
        wait_idle(2000, "captime_idle");
        check("captime_drained", sb.size(), 0);
        cap_time = 8'd5;
        repeat (2) tick();
        check("captime_clear", err_captime, 0);

        // Narrow counters saturate.
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        s_stop = 1'b1;
        tick();
        s_stop = 1'b0;
        begin
            int n = 0;
            while (!s_rec_valid && n < 2000) begin
                tick();
                n++;
            end
        end
        check("sat_ch0", {s_rec_valid, s_rec_step, s_rec_dir, s_rec_chan, s_rec_count},
              {1'b1, 8'd0, 1'b1, 1'b0, 2'd3});
        tick();
        check("sat_ch1", {s_rec_valid, s_rec_chan, s_rec_count}, {1'b1, 1'b1, 2'd3});
        begin
            int n = 0;
            while (s_busy && n < 500) begin
                tick();
                n++;
            end
        end
        check("sat_idle", {s_busy, s_err_timeout, s_err_captime, s_phase_updown}, 4'b0001);
        check("sat_period_range", s_period_cnt < 8'd16, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
